instr_encoder_loader: RTL and testbench

Encoder counterpart to the control decode path. It accepts symbolic instruction descriptors over a valid/ready stream and packs them into 32-bit instruction words for the R-type, lw, sw, beq and addi formats. It writes each word to instruction memory at consecutive word addresses, and is used by the boot/test loader to fill instruction memory before the core runs.

---
 rtl/instr_encoder_loader_pkg.sv | 36 +++
 rtl/instr_encoder_loader_if.sv | 36 +++
 rtl/instr_encoder_loader_field_encoder.sv | 23 ++
 rtl/instr_encoder_loader.sv | 122 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared types and constants for the instruction encoder/loader.
// Opcode constants are common with the control decode path.
package instr_encoder_loader_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned KIND_W = 3;
   localparam int unsigned OP_W   = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

   localparam logic [KIND_W-1:0] KIND_R    = 3'd0;
   localparam logic [KIND_W-1:0] KIND_LW   = 3'd1;
   localparam logic [KIND_W-1:0] KIND_SW   = 3'd2;
   localparam logic [KIND_W-1:0] KIND_BEQ  = 3'd3;
   localparam logic [KIND_W-1:0] KIND_ADDI = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_e;

   typedef struct packed {
      logic [KIND_W-1:0] kind;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd;
      logic [5:0]        funct;
      logic [15:0]       imm;
   } desc_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Descriptor stream, session control and instruction-memory write bus.
interface instr_encoder_loader_if #(
   parameter int unsigned ADDR_W = 8
) ();

   logic                                       start;
   logic [ADDR_W-1:0]                          base_addr;
   logic [ADDR_W-1:0]                          num_instr;
   logic                                       in_valid;
   logic                                       in_ready;
   logic [instr_encoder_loader_pkg::KIND_W-1:0] in_kind;
   logic [4:0]                                 in_rs;
   logic [4:0]                                 in_rt;
   logic [4:0]                                 in_rd;
   logic [5:0]                                 in_funct;
   logic [15:0]                                in_imm;
   logic                                       mem_we;
   logic [ADDR_W-1:0]                          mem_addr;
   logic [instr_encoder_loader_pkg::WORD_W-1:0] mem_wdata;
   logic                                       busy;
   logic                                       done;
   logic                                       err;

   modport master (
      output start, base_addr, num_instr, in_valid,
      output in_kind, in_rs, in_rt, in_rd, in_funct, in_imm,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
   );

   modport slave (
      input  start, base_addr, num_instr, in_valid,
      input  in_kind, in_rs, in_rt, in_rd, in_funct, in_imm,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
   );

endinterface

// File: rtl/instr_encoder_loader_field_encoder.sv
// Combinational packer: symbolic descriptor to 32-bit instruction word.
module instr_field_encoder
   import instr_encoder_loader_pkg::*;
(
   input  desc_t             desc,
   output logic [WORD_W-1:0] word,
   output logic              illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (desc.kind)
         KIND_R:    word = {OP_RTYPE, desc.rs, desc.rt, desc.rd, 5'd0, desc.funct};
         KIND_LW:   word = {OP_LW,    desc.rs, desc.rt, desc.imm};
         KIND_SW:   word = {OP_SW,    desc.rs, desc.rt, desc.imm};
         KIND_BEQ:  word = {OP_BEQ,   desc.rs, desc.rt, desc.imm};
         KIND_ADDI: word = {OP_ADDI,  desc.rs, desc.rt, desc.imm};
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Load-session FSM: consumes descriptors and writes encoded words to
// consecutive instruction-memory addresses.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input logic                  clk,
   input logic                  reset,
   instr_encoder_loader_if.slave bus
);

   state_e              state, state_n;
   logic [ADDR_W-1:0]   addr, addr_n;
   logic [ADDR_W-1:0]   remaining, remaining_n;
   logic                we_q, we_n;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_n;
   logic [WORD_W-1:0]   wdata_q, wdata_n;
   logic                done_q, done_n;
   logic                err_q, err_n;
   logic                ready_q, ready_n;
   logic                busy_q, busy_n;

   desc_t               desc;
   logic [WORD_W-1:0]   enc_word;
   logic                enc_illegal;
   logic                handshake;

   assign desc = {bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_funct, bus.in_imm};

   instr_field_encoder u_enc (
      .desc    (desc),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   assign handshake = bus.in_valid && ready_q;

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      addr_n      = addr;
      remaining_n = remaining;
      we_n        = 1'b0;
      mem_addr_n  = mem_addr_q;
      wdata_n     = wdata_q;
      done_n      = 1'b0;
      err_n       = err_q;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               err_n = 1'b0;
               if (bus.num_instr != '0) begin
                  state_n     = S_LOAD;
                  addr_n      = bus.base_addr;
                  remaining_n = bus.num_instr;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (handshake) begin
               remaining_n = remaining - ADDR_W'(1);
               // Illegal descriptors consume a slot but never write or advance addr
               if (enc_illegal) begin
                  err_n = 1'b1;
               end else begin
                  we_n       = 1'b1;
                  mem_addr_n = addr;
                  wdata_n    = enc_word;
                  addr_n     = addr + ADDR_W'(1);
               end
               if (remaining == ADDR_W'(1)) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      ready_n = (state_n == S_LOAD);
      busy_n  = (state_n != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         addr       <= '0;
         remaining  <= '0;
         we_q       <= 1'b0;
         mem_addr_q <= '0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state      <= state_n;
         addr       <= addr_n;
         remaining  <= remaining_n;
         we_q       <= we_n;
         mem_addr_q <= mem_addr_n;
         wdata_q    <= wdata_n;
         done_q     <= done_n;
         err_q      <= err_n;
         ready_q    <= ready_n;
         busy_q     <= busy_n;
      end
   end

   assign bus.in_ready  = ready_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader.
module tb_instr_encoder_loader;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   instr_encoder_loader_if #(.ADDR_W(8)) bus ();

   instr_encoder_loader #(.ADDR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] W_ADD  = 32'h0022_1820;
   localparam logic [31:0] W_LW   = 32'h8D28_0004;
   localparam logic [31:0] W_SW   = 32'hAFA8_FFFC;
   localparam logic [31:0] W_BEQ  = 32'h1022_0003;
   localparam logic [31:0] W_ADDI = 32'h2002_0005;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {mem_we, mem_addr, mem_wdata, done}
   function automatic logic [41:0] cur();
      return {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.done};
   endfunction

   function automatic logic [41:0] pack(input logic we, input logic [7:0] a,
                                        input logic [31:0] d, input logic dn);
      return {we, a, d, dn};
   endfunction

   // {busy, in_ready, err}
   function automatic logic [2:0] stat();
      return {bus.busy, bus.in_ready, bus.err};
   endfunction

   task automatic set_desc(input int idx, input logic v);
      bus.in_valid = v;
      case (idx)
         0: begin bus.in_kind = 3'd0; bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_rd = 5'd3;
                  bus.in_funct = 6'h20; bus.in_imm = 16'hDEAD; end
         1: begin bus.in_kind = 3'd1; bus.in_rs = 5'd9; bus.in_rt = 5'd8; bus.in_rd = 5'd31;
                  bus.in_funct = 6'h3F; bus.in_imm = 16'h0004; end
         2: begin bus.in_kind = 3'd2; bus.in_rs = 5'd29; bus.in_rt = 5'd8; bus.in_rd = 5'd0;
                  bus.in_funct = 6'h00; bus.in_imm = 16'hFFFC; end
         3: begin bus.in_kind = 3'd3; bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_rd = 5'd7;
                  bus.in_funct = 6'h11; bus.in_imm = 16'h0003; end
         4: begin bus.in_kind = 3'd4; bus.in_rs = 5'd0; bus.in_rt = 5'd2; bus.in_rd = 5'd0;
                  bus.in_funct = 6'h00; bus.in_imm = 16'h0005; end
         default: begin bus.in_kind = 3'd6; bus.in_rs = 5'd4; bus.in_rt = 5'd5; bus.in_rd = 5'd6;
                  bus.in_funct = 6'h01; bus.in_imm = 16'h1234; end
      endcase
   endtask

   task automatic begin_session(input logic [7:0] base, input logic [7:0] num);
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.num_instr = num;
      step();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      logic [41:0] o;
      logic [2:0]  s;
      reset = 1'b1;
      step();
      step();
      o = cur();
      n_cmp++;
      if (o !== pack(1'b0, 8'h00, 32'h0, 1'b0)) begin
         n_bad++; $display("FAIL reset_outputs got %h want %h", o, pack(1'b0, 8'h00, 32'h0, 1'b0));
      end
      s = stat();
      n_cmp++;
      if (s !== 3'b000) begin n_bad++; $display("FAIL reset_status got %b want 000", s); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      logic [41:0] o, e;
      logic [2:0]  s;
      logic [31:0] words [5];
      words = '{W_ADD, W_LW, W_SW, W_BEQ, W_ADDI};
      begin_session(8'h10, 8'd5);
      s = stat();
      n_cmp++;
      if (s !== 3'b110) begin n_bad++; $display("FAIL basic_enter_load got %b want 110", s); end
      for (int i = 0; i < 5; i++) begin
         set_desc(i, 1'b1);
         step();
         o = cur();
         e = pack(1'b1, 8'h10 + 8'(i), words[i], i == 4);
         n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL basic_write%0d got %h want %h", i, o, e); end
      end
      bus.in_valid = 1'b0;
      s = stat();
      n_cmp++;
      if (s !== 3'b100) begin n_bad++; $display("FAIL basic_done_state got %b want 100", s); end
      step();
      s = stat();
      o = cur();
      n_cmp++;
      if (s !== 3'b000 || o !== pack(1'b0, 8'h14, W_ADDI, 1'b0)) begin
         n_bad++; $display("FAIL basic_idle got %b/%h want 000/%h", s, o, pack(1'b0, 8'h14, W_ADDI, 1'b0));
      end
   endtask

   task automatic test_illegal();
      logic [41:0] o, e;
      logic [2:0]  s;
      begin_session(8'h20, 8'd3);
      set_desc(0, 1'b1);
      step();
      o = cur(); e = pack(1'b1, 8'h20, W_ADD, 1'b0);
      n_cmp++;
      if (o !== e || bus.err !== 1'b0) begin
         n_bad++; $display("FAIL illegal_w0 got %h err %b want %h err 0", o, bus.err, e);
      end
      set_desc(7, 1'b1);
      step();
      o = cur(); e = pack(1'b0, 8'h20, W_ADD, 1'b0);
      n_cmp++;
      if (o !== e || bus.err !== 1'b1) begin
         n_bad++; $display("FAIL illegal_skip got %h err %b want %h err 1", o, bus.err, e);
      end
      set_desc(1, 1'b1);
      step();
      o = cur(); e = pack(1'b1, 8'h21, W_LW, 1'b1);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL illegal_w1 got %h want %h", o, e); end
      bus.in_valid = 1'b0;
      step();
      step();
      s = stat();
      n_cmp++;
      if (s !== 3'b001) begin n_bad++; $display("FAIL illegal_err_sticky got %b want 001", s); end
   endtask

   task automatic test_zero();
      logic [41:0] o;
      logic [2:0]  s;
      begin_session(8'h33, 8'd0);
      o = cur(); s = stat();
      n_cmp++;
      if (o[41] !== 1'b0 || o[0] !== 1'b1 || s !== 3'b000) begin
         n_bad++; $display("FAIL zero_done got we=%b done=%b stat=%b want we=0 done=1 stat=000", o[41], o[0], s);
      end
      step();
      o = cur(); s = stat();
      n_cmp++;
      if (o[41] !== 1'b0 || o[0] !== 1'b0 || s !== 3'b000) begin
         n_bad++; $display("FAIL zero_after got we=%b done=%b stat=%b want 0 0 000", o[41], o[0], s);
      end
   endtask

   task automatic test_wrap();
      logic [41:0] o, e;
      begin_session(8'hFF, 8'd2);
      set_desc(3, 1'b1);
      step();
      o = cur(); e = pack(1'b1, 8'hFF, W_BEQ, 1'b0);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL wrap_ff got %h want %h", o, e); end
      set_desc(4, 1'b1);
      step();
      o = cur(); e = pack(1'b1, 8'h00, W_ADDI, 1'b1);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL wrap_00 got %h want %h", o, e); end
      bus.in_valid = 1'b0;
      step();
   endtask

   task automatic test_stall();
      logic [41:0] o, e;
      logic [3:0]  pat;
      int          k;
      pat = 4'b1001;
      k = 0;
      begin_session(8'h40, 8'd2);
      for (int c = 0; c < 4; c++) begin
         set_desc(k == 0 ? 2 : 0, pat[c]);
         step();
         if (pat[c]) begin
            e = pack(1'b1, 8'h40 + 8'(k), k == 0 ? W_SW : W_ADD, k == 1);
            k++;
         end else begin
            e = pack(1'b0, 8'h40, W_SW, 1'b0);
         end
         o = cur();
         n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL stall_c%0d got %h want %h", c, o, e); end
      end
      bus.in_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      logic [41:0] o, e;
      logic [2:0]  s;
      begin_session(8'h50, 8'd4);
      for (int i = 0; i < 2; i++) begin
         set_desc(i, 1'b1);
         step();
         o = cur(); e = pack(1'b1, 8'h50 + 8'(i), i == 0 ? W_ADD : W_LW, 1'b0);
         n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL mid_w%0d got %h want %h", i, o, e); end
      end
      set_desc(2, 1'b1);
      reset = 1'b1;
      #1;
      s = stat();
      n_cmp++;
      if (bus.mem_we !== 1'b0 || s !== 3'b000) begin
         n_bad++; $display("FAIL mid_async got we=%b stat=%b want 0 000", bus.mem_we, s);
      end
      step();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         s = stat();
         n_cmp++;
         if (bus.mem_we !== 1'b0 || s !== 3'b000) begin
            n_bad++; $display("FAIL mid_quiet%0d got we=%b stat=%b want 0 000", c, bus.mem_we, s);
         end
      end
      bus.in_valid = 1'b0;
      begin_session(8'h60, 8'd2);
      bus.start = 1'b1;
      bus.base_addr = 8'h70;
      bus.num_instr = 8'd5;
      set_desc(1, 1'b1);
      step();
      o = cur(); e = pack(1'b1, 8'h60, W_LW, 1'b0);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL restart_w0 got %h want %h", o, e); end
      bus.start = 1'b0;
      set_desc(4, 1'b1);
      step();
      o = cur(); e = pack(1'b1, 8'h61, W_ADDI, 1'b1);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL restart_w1 got %h want %h", o, e); end
      bus.in_valid = 1'b0;
      step();
   endtask

   initial begin
      clk = 1'b0;
      reset = 1'b1;
      n_cmp = 0;
      n_bad = 0;
      bus.start = 1'b0;
      bus.base_addr = '0;
      bus.num_instr = '0;
      set_desc(0, 1'b0);
      test_reset();
      test_basic();
      test_illegal();
      test_zero();
      test_wrap();
      test_stall();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
